car_warning_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational car warning gate. Monitors any number of doors and seats while ignition is on, applies a grace period before warning, then drives a blinking lamp and time-limited chime that the driver can mute. Sits between the body-sensor inputs and the dashboard lamp/chime drivers.

---
 rtl/car_warning_ctrl_if.sv | 26 ++
 rtl/car_warning_ctrl.sv | 137 +++++++++++++
 tb/tb_car_warning_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/car_warning_ctrl_if.sv
// rtl/car_warning_ctrl_if.sv - body-sensor inputs and dashboard outputs of the warning controller
interface car_warning_ctrl_if #(
    parameter int NUM_DOORS = 4,
    parameter int NUM_SEATS = 2
);
    logic                 Ignition;
    logic [NUM_DOORS-1:0] DoorClose;
    logic [NUM_SEATS-1:0] Occupied;
    logic [NUM_SEATS-1:0] SeatBelt;
    logic                 Ack;
    logic                 Warning;
    logic                 Lamp;
    logic                 Chime;
    logic                 DoorWarn;
    logic [NUM_SEATS-1:0] BeltWarn;

    modport master (
        output Ignition, DoorClose, Occupied, SeatBelt, Ack,
        input  Warning, Lamp, Chime, DoorWarn, BeltWarn
    );

    modport slave (
        input  Ignition, DoorClose, Occupied, SeatBelt, Ack,
        output Warning, Lamp, Chime, DoorWarn, BeltWarn
    );
endinterface

// File: rtl/car_warning_ctrl.sv
// rtl/car_warning_ctrl.sv - door/belt warning FSM with grace period, blinking lamp and mutable chime
module car_warning_ctrl #(
    parameter int NUM_DOORS   = 4,
    parameter int NUM_SEATS   = 2,
    parameter int TICK_DIV    = 1000,
    parameter int GRACE_TICKS = 5,
    parameter int CHIME_TICKS = 30,
    parameter int BLINK_HALF  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    car_warning_ctrl_if.slave   bus
);
    localparam int NF = NUM_DOORS + NUM_SEATS;
    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam int GW = $clog2(GRACE_TICKS) + 1;
    localparam int CW = $clog2(CHIME_TICKS + 1) + 1;
    localparam int BW = $clog2(BLINK_HALF) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRACE = 2'd1;
    localparam logic [1:0] ALARM = 2'd2;
    localparam logic [1:0] MUTED = 2'd3;

    logic                 ign_q;
    logic [NUM_DOORS-1:0] door_q;
    logic [NUM_SEATS-1:0] occ_q;
    logic [NUM_SEATS-1:0] belt_q;
    logic                 ack_s;
    logic                 ack_q;
    logic                 ack_qq;
    logic                 door_warn;
    logic [NUM_SEATS-1:0] belt_warn;

    logic [1:0]    state;
    logic [1:0]    nxt;
    logic [PW-1:0] pre;
    logic [GW-1:0] grace_cnt;
    logic [BW-1:0] blink_cnt;
    logic [CW-1:0] chime_cnt;
    logic          lamp_on;
    logic [NF-1:0] mask;

    logic [NF-1:0] f;
    logic          fault;
    logic          ack_edge;
    logic          tick;

    assign f        = {{NUM_DOORS{ign_q}} & ~door_q, {NUM_SEATS{ign_q}} & occ_q & ~belt_q};
    assign fault    = |f;
    assign ack_edge = ack_q & ~ack_qq;
    assign tick     = (pre == PW'(TICK_DIV - 1));

    // Losing every fault source overrides all other transitions.
    always_comb begin
        nxt = state;
        if (!fault) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    nxt = GRACE;
                GRACE:   if (tick && grace_cnt == GW'(GRACE_TICKS - 1)) nxt = ALARM;
                ALARM:   if (ack_edge) nxt = MUTED;
                MUTED:   if (|(f & ~mask)) nxt = ALARM;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ign_q     <= 1'b0;
            door_q    <= '0;
            occ_q     <= '0;
            belt_q    <= '0;
            ack_s     <= 1'b0;
            ack_q     <= 1'b0;
            ack_qq    <= 1'b0;
            door_warn <= 1'b0;
            belt_warn <= '0;
            state     <= IDLE;
            pre       <= '0;
            grace_cnt <= '0;
            blink_cnt <= '0;
            chime_cnt <= '0;
            lamp_on   <= 1'b0;
            mask      <= '0;
        end else begin
            ign_q     <= bus.Ignition;
            door_q    <= bus.DoorClose;
            occ_q     <= bus.Occupied;
            belt_q    <= bus.SeatBelt;
            ack_s     <= bus.Ack;
            ack_q     <= ack_s;
            ack_qq    <= ack_q;
            door_warn <= |({NUM_DOORS{bus.Ignition}} & ~bus.DoorClose);
            belt_warn <= {NUM_SEATS{bus.Ignition}} & bus.Occupied & ~bus.SeatBelt;
            state     <= nxt;

            // Every transition restarts timing, so ALARM re-entry always begins lamp-on with a fresh chime.
            if (nxt != state) begin
                pre       <= '0;
                grace_cnt <= '0;
                blink_cnt <= '0;
                chime_cnt <= '0;
                lamp_on   <= 1'b1;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick && state == GRACE && grace_cnt != GW'(GRACE_TICKS))
                    grace_cnt <= grace_cnt + 1'b1;
                if (tick && state == ALARM) begin
                    if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                        blink_cnt <= '0;
                        lamp_on   <= ~lamp_on;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                    if (chime_cnt != CW'(CHIME_TICKS))
                        chime_cnt <= chime_cnt + 1'b1;
                end
            end

            if (state == ALARM && nxt == MUTED)
                mask <= f;
            else if (state == MUTED)
                mask <= mask & f;
            else if (state == IDLE)
                mask <= '0;
        end
    end

    assign bus.Warning  = (state == ALARM) || (state == MUTED);
    assign bus.Lamp     = ((state == ALARM) && lamp_on) || (state == MUTED);
    assign bus.Chime    = (state == ALARM) && lamp_on && (chime_cnt < CW'(CHIME_TICKS));
    assign bus.DoorWarn = door_warn;
    assign bus.BeltWarn = belt_warn;
endmodule

// File: tb/tb_car_warning_ctrl.sv
// tb/tb_car_warning_ctrl.sv - scoreboard bench for car_warning_ctrl against a cycle-count reference model
module tb_car_warning_ctrl;
    localparam int ND = 2;
    localparam int NS = 2;
    localparam int TD = 4;
    localparam int GT = 3;
    localparam int CT = 6;
    localparam int BH = 2;

    localparam int S_IDLE  = 0;
    localparam int S_GRACE = 1;
    localparam int S_ALARM = 2;
    localparam int S_MUTED = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ign;
    logic [ND-1:0] door;
    logic [NS-1:0] occ;
    logic [NS-1:0] belt;
    logic          ack;

    car_warning_ctrl_if #(.NUM_DOORS(ND), .NUM_SEATS(NS)) bus ();

    assign bus.Ignition  = ign;
    assign bus.DoorClose = door;
    assign bus.Occupied  = occ;
    assign bus.SeatBelt  = belt;
    assign bus.Ack       = ack;

    car_warning_ctrl #(
        .NUM_DOORS(ND), .NUM_SEATS(NS), .TICK_DIV(TD),
        .GRACE_TICKS(GT), .CHIME_TICKS(CT), .BLINK_HALF(BH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ign;
        logic [ND-1:0] door;
        logic [NS-1:0] occ;
        logic [NS-1:0] belt;
    } in_t;

    logic [5:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    // Reference model: states timed in raw clock cycles rather than prescaled ticks.
    in_t             prev_in;
    logic            a1, a2, a3;
    int              st, cnt, el;
    logic [ND+NS-1:0] msk;

    function automatic logic [ND+NS-1:0] fvec(input in_t x);
        return {{ND{x.ign}} & ~x.door, {NS{x.ign}} & x.occ & ~x.belt};
    endfunction

    task automatic model_edge();
        in_t              cur;
        logic [ND+NS-1:0] fv;
        logic             ae, w, l, c, dw;
        logic [NS-1:0]    bw;
        cur = '{ign: ign, door: door, occ: occ, belt: belt};
        if (!rst_n) begin
            st = S_IDLE; cnt = 0; el = 0; msk = '0;
            prev_in = '0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
            exp_q.push_back(6'b0);
            return;
        end
        fv = fvec(prev_in);
        ae = a2 & ~a3;
        if (fv == '0) begin
            st = S_IDLE;
        end else if (st == S_IDLE) begin
            st = S_GRACE; cnt = 0;
        end else if (st == S_GRACE) begin
            cnt++;
            if (cnt == GT * TD) begin st = S_ALARM; el = 0; end
        end else if (st == S_ALARM) begin
            if (ae) begin st = S_MUTED; msk = fv; end
            else el++;
        end else begin
            if ((fv & ~msk) != '0) begin st = S_ALARM; el = 0; end
            else msk = msk & fv;
        end
        w  = (st == S_ALARM) || (st == S_MUTED);
        l  = (st == S_MUTED) || ((st == S_ALARM) && ((el / (BH * TD)) % 2 == 0));
        c  = (st == S_ALARM) && l && (el < CT * TD);
        dw = |(cur.ign ? ~cur.door : '0);
        bw = {NS{cur.ign}} & cur.occ & ~cur.belt;
        exp_q.push_back({w, l, c, dw, bw});
        a3 = a2; a2 = a1; a1 = ack;
        prev_in = cur;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            cycle++;
            #1;
        end
    endtask

    initial begin : monitor
        logic [5:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.Warning, bus.Lamp, bus.Chime, bus.DoorWarn, bus.BeltWarn};
                checks++;
                if (a !== e)
                    $display("FAIL outputs cyc=%0d {warn,lamp,chime,doorwarn,beltwarn} actual=%b expected=%b",
                             cycle, a, e);
                else
                    passed++;
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; ign = 1'b0; door = '1; occ = '0; belt = '0; ack = 1'b0;
        cyc(2);
        rst_n = 1'b1; ign = 1'b1;
        cyc(200);
        door[0] = 1'b0;
        cyc(60);
        door[0] = 1'b1;
        cyc(5);
        occ[1] = 1'b1;
        cyc(8);
        belt[1] = 1'b1;
        cyc(5);
        belt[1] = 1'b0;
        cyc(20);
        ack = 1'b1;
        cyc(2);
        ack = 1'b0;
        cyc(10);
        door[1] = 1'b0;
        cyc(20);
        ign = 1'b0; ack = 1'b1;
        cyc(5);
        ack = 1'b0; ign = 1'b1; occ = '0; door = 2'b10;
        cyc(20);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(20);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) door[$urandom_range(0, ND - 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) occ[$urandom_range(0, NS - 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) belt[$urandom_range(0, NS - 1)] ^= 1'b1;
            if ($urandom_range(0, 149) == 0) ign ^= 1'b1;
            if ($urandom_range(0, 19) == 0) ack ^= 1'b1;
            rst_n = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain pending actual=%0d expected=0", exp_q.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
